// File: rtl/dlatch_mon_pkg.sv
// rtl/dlatch_mon_pkg.sv - state encoding and default parameters for the latch monitor
package dlatch_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_HALT   = 2'd3
    } mon_state_t;

    localparam int DEF_SETTLE = 4;
    localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dlatch_rst_monitor.sv
// rtl/dlatch_rst_monitor.sv - observer that models a reset-able D latch and checks its q
module dlatch_rst_monitor
    import dlatch_mon_pkg::*;
#(
    parameter int SETTLE       = DEF_SETTLE,
    parameter int CNT_W        = DEF_CNT_W,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic             mon_d,
    input  logic             mon_en,
    input  logic             mon_rst,
    input  logic             mon_q,
    output logic             exp_q,
    output logic             checking,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [CNT_W-1:0] check_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    mon_state_t  state;
    logic [SW-1:0] settle_cnt;

    logic s_d, s_en, s_rst, s_q;
    logic p_d, p_en, p_rst;
    logic chg, do_check, err_hit;

    // One sample stage plus the previous sample, used for change detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_d   <= 1'b0;
            s_en  <= 1'b0;
            s_rst <= 1'b0;
            s_q   <= 1'b0;
            p_d   <= 1'b0;
            p_en  <= 1'b0;
            p_rst <= 1'b0;
        end else begin
            s_d   <= mon_d;
            s_en  <= mon_en;
            s_rst <= mon_rst;
            s_q   <= mon_q;
            p_d   <= s_d;
            p_en  <= s_en;
            p_rst <= s_rst;
        end
    end

    assign chg      = (s_d ^ p_d) | (s_en ^ p_en) | (s_rst ^ p_rst);
    assign do_check = (state == ST_CHECK) && enable && !chg && !clear;
    assign err_hit  = do_check && (s_q != exp_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            exp_q      <= 1'b0;
            checking   <= 1'b0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            // Latch reset dominates enable; model freezes only while halted
            if (state != ST_HALT) begin
                if (s_rst) begin
                    exp_q <= 1'b0;
                end else if (s_en) begin
                    exp_q <= s_d;
                end
            end

            err_pulse <= err_hit;
            if (clear) begin
                err_sticky <= 1'b0;
            end else if (err_hit) begin
                err_sticky <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (chg) begin
                        settle_cnt <= '0;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        state    <= ST_CHECK;
                        checking <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (!enable) begin
                        state    <= ST_IDLE;
                        checking <= 1'b0;
                    end else if (chg) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                        checking   <= 1'b0;
                    end else if (err_hit && STOP_ON_FAIL) begin
                        state    <= ST_HALT;
                        checking <= 1'b0;
                    end
                end
                ST_HALT: begin
                    if (clear) begin
                        state      <= enable ? ST_SETTLE : ST_IDLE;
                        settle_cnt <= '0;
                    end
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_check_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clear),
        .inc (do_check),
        .cnt (check_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clear),
        .inc (err_hit),
        .cnt (err_cnt)
    );

endmodule

// File: tb/tb_dlatch_rst_monitor.sv
// tb/tb_dlatch_rst_monitor.sv - directed self-checking bench for dlatch_rst_monitor
module tb_dlatch_rst_monitor;
    import dlatch_mon_pkg::*;

    logic clk, rst, enable, clear;
    logic mon_d, mon_en, mon_rst, mon_q;

    logic        a_exp_q, a_checking, a_err_pulse, a_err_sticky;
    logic [15:0] a_check_cnt, a_err_cnt;
    logic        b_exp_q, b_checking, b_err_pulse, b_err_sticky;
    logic [15:0] b_check_cnt, b_err_cnt;
    logic        c_exp_q, c_checking, c_err_pulse, c_err_sticky;
    logic [2:0]  c_check_cnt, c_err_cnt;

    int n_cmp = 0;
    int n_err = 0;

    dlatch_rst_monitor #(.SETTLE(4), .CNT_W(16), .STOP_ON_FAIL(1'b0)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .mon_d(mon_d), .mon_en(mon_en), .mon_rst(mon_rst), .mon_q(mon_q),
        .exp_q(a_exp_q), .checking(a_checking), .err_pulse(a_err_pulse),
        .err_sticky(a_err_sticky), .check_cnt(a_check_cnt), .err_cnt(a_err_cnt)
    );

    dlatch_rst_monitor #(.SETTLE(4), .CNT_W(16), .STOP_ON_FAIL(1'b1)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .mon_d(mon_d), .mon_en(mon_en), .mon_rst(mon_rst), .mon_q(mon_q),
        .exp_q(b_exp_q), .checking(b_checking), .err_pulse(b_err_pulse),
        .err_sticky(b_err_sticky), .check_cnt(b_check_cnt), .err_cnt(b_err_cnt)
    );

    dlatch_rst_monitor #(.SETTLE(4), .CNT_W(3), .STOP_ON_FAIL(1'b0)) dut_c (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .mon_d(mon_d), .mon_en(mon_en), .mon_rst(mon_rst), .mon_q(mon_q),
        .exp_q(c_exp_q), .checking(c_checking), .err_pulse(c_err_pulse),
        .err_sticky(c_err_sticky), .check_cnt(c_check_cnt), .err_cnt(c_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_a_zero(input string tag);
        chk({tag, "_exp_q"},      16'(a_exp_q),      16'd0);
        chk({tag, "_checking"},   16'(a_checking),   16'd0);
        chk({tag, "_err_pulse"},  16'(a_err_pulse),  16'd0);
        chk({tag, "_err_sticky"}, 16'(a_err_sticky), 16'd0);
        chk({tag, "_check_cnt"},  a_check_cnt,       16'd0);
        chk({tag, "_err_cnt"},    a_err_cnt,         16'd0);
        chk({tag, "_state"},      16'(dut_a.state),  16'(ST_IDLE));
    endtask

    initial begin
        // Reset with random latch-side inputs
        rst     = 1'b0;
        enable  = 1'b0;
        clear   = 1'b0;
        mon_d   = 1'($urandom);
        mon_en  = 1'($urandom);
        mon_rst = 1'($urandom);
        mon_q   = 1'($urandom);
        tick(3);
        chk_a_zero("rst");

        // Released but disabled: model tracks, FSM stays idle
        rst = 1'b1; mon_d = 1'b1; mon_en = 1'b1; mon_rst = 1'b0; mon_q = 1'b1;
        tick(3);
        chk("idle_state",    16'(dut_a.state), 16'(ST_IDLE));
        chk("idle_checking", 16'(a_checking),  16'd0);
        chk("idle_exp_q",    16'(a_exp_q),     16'd1);

        // Good latch: CHECK after 5 clocks, 5 compares after 10
        enable = 1'b1;
        tick(4);
        chk("settle_checking", 16'(a_checking), 16'd0);
        tick(1);
        chk("check_entry_a", 16'(a_checking), 16'd1);
        chk("check_entry_b", 16'(b_checking), 16'd1);
        tick(5);
        chk("good_check_cnt",   a_check_cnt,      16'd5);
        chk("good_err_cnt",     a_err_cnt,        16'd0);
        chk("good_c_check_cnt", 16'(c_check_cnt), 16'd5);

        // Fault: q stuck low for 3 clocks
        mon_q = 1'b0;
        tick(1);
        chk("fault_pulse0", 16'(a_err_pulse), 16'd0);
        tick(1);
        chk("fault_pulse1",   16'(a_err_pulse), 16'd1);
        chk("fault_b_pulse",  16'(b_err_pulse), 16'd1);
        chk("fault_b_halt",   16'(dut_b.state), 16'(ST_HALT));
        tick(1);
        chk("fault_pulse2",   16'(a_err_pulse), 16'd1);
        chk("fault_b_pulse0", 16'(b_err_pulse), 16'd0);
        mon_q = 1'b1;
        tick(1);
        chk("fault_pulse3", 16'(a_err_pulse), 16'd1);
        tick(1);
        chk("fault_pulse_end",  16'(a_err_pulse),  16'd0);
        chk("fault_err_cnt",    a_err_cnt,         16'd3);
        chk("fault_sticky",     16'(a_err_sticky), 16'd1);
        chk("fault_check_cnt",  a_check_cnt,       16'd10);
        chk("sat_c_check_cnt",  16'(c_check_cnt),  16'd7);
        chk("sat_c_err_cnt",    16'(c_err_cnt),    16'd3);
        chk("halt_b_err_cnt",   b_err_cnt,         16'd1);
        chk("halt_b_check_cnt", b_check_cnt,       16'd7);
        chk("halt_b_state",     16'(dut_b.state),  16'(ST_HALT));
        chk("halt_b_checking",  16'(b_checking),   16'd0);
        chk("halt_b_sticky",    16'(b_err_sticky), 16'd1);

        // Clear: counters and sticky drop, HALT exits to SETTLE
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk("clr_check_cnt", a_check_cnt,       16'd0);
        chk("clr_err_cnt",   a_err_cnt,         16'd0);
        chk("clr_sticky",    16'(a_err_sticky), 16'd0);
        chk("clr_checking",  16'(a_checking),   16'd1);
        chk("clr_b_state",   16'(dut_b.state),  16'(ST_SETTLE));
        chk("clr_b_err_cnt", b_err_cnt,         16'd0);

        // clear in the same cycle as a mismatching compare
        tick(2);
        chk("pre_clr_check_cnt", a_check_cnt, 16'd2);
        mon_q = 1'b0;
        tick(1);
        clear = 1'b1;
        mon_q = 1'b1;
        tick(1);
        clear = 1'b0;
        chk("clrmis_pulse",     16'(a_err_pulse),  16'd0);
        chk("clrmis_err_cnt",   a_err_cnt,         16'd0);
        chk("clrmis_sticky",    16'(a_err_sticky), 16'd0);
        chk("clrmis_check_cnt", a_check_cnt,       16'd0);

        // Latch reset dominates enable
        mon_rst = 1'b1; mon_en = 1'b1; mon_d = 1'b1; mon_q = 1'b0;
        tick(8);
        chk("prio_exp_q",     16'(a_exp_q),      16'd0);
        chk("prio_checking",  16'(a_checking),   16'd1);
        chk("prio_check_cnt", a_check_cnt,       16'd3);
        chk("prio_err_cnt",   a_err_cnt,         16'd0);
        chk("prio_sticky",    16'(a_err_sticky), 16'd0);

        // Closed latch holds q=1 while d drops
        mon_rst = 1'b0; mon_q = 1'b1;
        tick(2);
        mon_en = 1'b0;
        tick(2);
        mon_d = 1'b0;
        tick(8);
        chk("hold_exp_q",    16'(a_exp_q),    16'd1);
        chk("hold_err_cnt",  a_err_cnt,       16'd0);
        chk("hold_checking", 16'(a_checking), 16'd1);

        // Toggling d every 2 clocks never settles
        mon_d = 1'b1;
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(1);
        chk("tog_start_checking", 16'(a_checking), 16'd0);
        for (int i = 0; i < 10; i++) begin
            mon_d = ~mon_d;
            tick(1);
            chk("tog_checking", 16'(a_checking), 16'd0);
            tick(1);
            chk("tog_checking", 16'(a_checking), 16'd0);
        end
        chk("tog_check_cnt", a_check_cnt, 16'd0);
        tick(3);
        chk("tog_stop_settle", 16'(a_checking), 16'd0);
        tick(1);
        chk("tog_stop_check", 16'(a_checking), 16'd1);
        chk("tog_stop_cnt",   a_check_cnt,     16'd0);

        // Asynchronous reset mid-CHECK
        tick(2);
        chk("pre_arst_check_cnt", a_check_cnt, 16'd2);
        #2;
        rst = 1'b0;
        #1;
        chk_a_zero("arst");
        chk("arst_c_check_cnt", 16'(c_check_cnt), 16'd0);
        @(negedge clk);
        rst = 1'b1;
        tick(2);
        chk("arst_after_checking", 16'(a_checking), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
